vc_buffer_bank: RTL
===================

# vc_buffer_bank

Multi-channel virtual-channel input buffer for a router port: NUM_VC independent FIFOs behind one shared write port, each with its own first-word-fall-through read port. It returns a one-cycle credit pulse per popped flit to the upstream credit counter. Write/read protocol errors are reported on sticky flags instead of being silently absorbed. It sits between the link receiver and the VC allocator / switch arbiter in each router input port, replacing per-VC single-FIFO instances.

## Interface
Parameters:
- NUM_VC, 4, number of virtual channels (>=1)
- DEPTH, 8, entries per VC (>=2, need not be a power of two)
- FLIT_W, $bits(flit_u), flit width in bits
- AF_THRESH, DEPTH-2, almost-full asserts when count >= AF_THRESH
- VC_W, max(1,$clog2(NUM_VC)), derived VC index width
- CNT_W, $clog2(DEPTH+1), derived count width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write request
- wr_vc  in  VC_W  target VC of write
- wr_data  in  FLIT_W  flit to write
- rd_req  in  NUM_VC  per-VC pop request; any combination may be set in one cycle
- rd_valid  out  NUM_VC  per-VC head valid (count != 0)
- rd_data  out  NUM_VC*FLIT_W  per-VC head flit, VC v at bits [v*FLIT_W +: FLIT_W]
- almost_full  out  NUM_VC  count >= AF_THRESH
- full  out  NUM_VC  count == DEPTH
- count  out  NUM_VC*CNT_W  per-VC occupancy
- credit_ret  out  NUM_VC  one-cycle pulse per accepted pop
- ovf_err  out  1  sticky: write dropped on full VC, or wr_vc >= NUM_VC
- udf_err  out  1  sticky: rd_req on empty VC
- clr_err  in  1  synchronous clear of both sticky flags

## Operation
- Each VC has its own storage, wr_ptr, rd_ptr and count. Pointers count 0..DEPTH-1 and wrap explicitly to 0; modulo on a power of two is not relied upon.
- Pop accepted on VC v iff rd_req[v] && count[v] != 0. rd_req[v] on an empty VC is ignored and sets udf_err.
- Write accepted iff wr_valid, wr_vc < NUM_VC, and either count[wr_vc] < DEPTH or a pop on wr_vc is accepted in the same cycle.
  - A write to a full VC with no same-cycle pop is dropped and sets ovf_err.
  - A write with an out-of-range wr_vc is dropped and sets ovf_err.
- Count update per VC:
  - write only: +1
  - pop only: -1
  - both or neither: unchanged
- A write to an empty VC in the same cycle as rd_req on that VC: the write is accepted, the pop is not (no valid head existed), and udf_err is set.
- rd_data[v] is the FWFT head, mem[rd_ptr], and is forced to 0 whenever rd_valid[v] == 0.
- credit_ret[v] is registered: it pulses for exactly one cycle, in the cycle after each accepted pop. Pops in consecutive cycles produce a continuous high.
- Sticky flags set on the edge after the offending cycle and hold until clr_err or reset. If clr_err coincides with a new error, the set wins.
- Reset mid-operation discards all contents immediately (asynchronous). No credits are returned for discarded flits; the upstream re-initialises its credit counters on the same reset.

## Timing
- Reset values:
  - count, rd_valid, full, almost_full, credit_ret, ovf_err, udf_err: 0
  - rd_data: 0
- Write latency: a flit written at edge N appears on rd_valid/rd_data after edge N, in cycle N+1.
- Pop: the head advances after the edge; the next entry is visible in the following cycle with no bubble. Each VC sustains one pop per cycle.
- Write-to-credit loop: a write at edge N can be popped at edge N+1, giving credit_ret in cycle N+2.
- full, almost_full and count are combinational from registered count (no extra delay).
- Throughput: one write per cycle across all VCs, plus up to NUM_VC simultaneous pops.

## Test plan
- Reset, then write 0xA1,0xA2,0xA3 to VC2 → rd_valid = 4'b0100, rd_data[2] = 0xA1; pop three times → 0xA2, 0xA3, then rd_valid[2] = 0; credit_ret[2] high for the 3 cycles following the pops.
- Fill VC1 with DEPTH=8 flits → full[1] = 1, almost_full[1] = 1 from count 6; a ninth write is dropped, count stays 8, ovf_err = 1; clr_err clears ovf_err.
- VC1 full, simultaneous write 0x55 and pop → write accepted, count stays 8, ovf_err stays 0; after 8 further pops the last data read is 0x55.
- Pointer wrap with DEPTH=6 (non-power-of-two): stream 20 flits through VC0 at an occupancy of 3 → data emerges in order and count never exceeds 6.
- Empty VC3 with rd_req[3] and a write 0x77 in the same cycle → udf_err = 1, count[3] = 1, rd_data[3] = 0x77 next cycle, no credit_ret pulse.
- Load VC0 and VC3 with 2 flits each, then assert rst_n low mid-stream → all counts 0, rd_data = 0, no credit_ret; after release, a new write behaves exactly as from power-up.

Source files
------------

// File: rtl/vc_buffer_bank.sv
// Per-VC input buffering for one router port: NUM_VC FWFT FIFOs behind a shared write port,
// with per-pop credit return and sticky overflow/underflow reporting.

package vc_buffer_bank_pkg;
    typedef logic [7:0] flit_u;
endpackage

module vc_buffer_bank #(
    parameter int NUM_VC    = 4,
    parameter int DEPTH     = 8,
    parameter int FLIT_W    = $bits(vc_buffer_bank_pkg::flit_u),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [VC_W-1:0]          wr_vc,
    input  logic [FLIT_W-1:0]        wr_data,
    input  logic [NUM_VC-1:0]        rd_req,
    output logic [NUM_VC-1:0]        rd_valid,
    output logic [NUM_VC*FLIT_W-1:0] rd_data,
    output logic [NUM_VC-1:0]        almost_full,
    output logic [NUM_VC-1:0]        full,
    output logic [NUM_VC*CNT_W-1:0]  count,
    output logic [NUM_VC-1:0]        credit_ret,
    output logic                     ovf_err,
    output logic                     udf_err,
    input  logic                     clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [VC_W:0]    NUM_VC_C = (VC_W + 1)'(NUM_VC);

    logic [FLIT_W-1:0] mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  cnt    [NUM_VC];

    logic [NUM_VC-1:0] pop_ok;
    logic [NUM_VC-1:0] push_ok;
    logic              wr_in_range;
    logic              ovf_set;
    logic              udf_set;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign wr_in_range = {1'b0, wr_vc} < NUM_VC_C;
    assign udf_set     = |(rd_req & ~rd_valid);

    // A full VC still accepts a write when its head is popped in the same cycle.
    always_comb begin
        pop_ok  = '0;
        push_ok = '0;
        ovf_set = wr_valid && !wr_in_range;
        for (int v = 0; v < NUM_VC; v++) begin
            pop_ok[v]  = rd_req[v] && (cnt[v] != '0);
            push_ok[v] = wr_valid && wr_in_range && (wr_vc == VC_W'(v))
                         && ((cnt[v] != DEPTH_C) || pop_ok[v]);
            if (wr_valid && (wr_vc == VC_W'(v)) && (cnt[v] == DEPTH_C) && !pop_ok[v])
                ovf_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_ok[v])
                mem[v][wr_ptr[v]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                cnt[v]    <= '0;
            end
            credit_ret <= '0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_ok[v])
                    wr_ptr[v] <= next_ptr(wr_ptr[v]);
                if (pop_ok[v])
                    rd_ptr[v] <= next_ptr(rd_ptr[v]);
                if (push_ok[v] && !pop_ok[v])
                    cnt[v] <= cnt[v] + 1'b1;
                else if (!push_ok[v] && pop_ok[v])
                    cnt[v] <= cnt[v] - 1'b1;
            end
            credit_ret <= pop_ok;
            // A new error outranks a coincident clear.
            if (ovf_set)
                ovf_err <= 1'b1;
            else if (clr_err)
                ovf_err <= 1'b0;
            if (udf_set)
                udf_err <= 1'b1;
            else if (clr_err)
                udf_err <= 1'b0;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_out
        assign rd_valid[v]                   = cnt[v] != '0;
        assign full[v]                       = cnt[v] == DEPTH_C;
        assign almost_full[v]                = cnt[v] >= AF_C;
        assign count[v*CNT_W +: CNT_W]       = cnt[v];
        assign rd_data[v*FLIT_W +: FLIT_W]   = rd_valid[v] ? mem[v][rd_ptr[v]] : '0;
    end

endmodule
